// File: rtl/inst_capture_pkg.sv
// Shared definitions for the nexys3 sequencer: instruction field layout,
// opcode encoding and the default button debounce interval.
package inst_capture_pkg;

  localparam int DATA_W         = 8;
  localparam int DEB_CYCLES_DEF = 250000;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_ADD  = 2'b01,
    OP_MULT = 2'b10,
    OP_SEND = 2'b11
  } opcode_e;

  // Instruction word layout: opcode in the top two bits, three 2-bit operand fields below.
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int F2_MSB = 5;
  localparam int F2_LSB = 4;
  localparam int F1_MSB = 3;
  localparam int F1_LSB = 2;
  localparam int F0_MSB = 1;
  localparam int F0_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cap_state_e;

endpackage

// File: rtl/inst_capture_if.sv
// Instruction hand-off between the capture stage (master) and the sequencer core (slave).
interface inst_capture_if;
  import inst_capture_pkg::*;

  logic              inst_rdy;
  logic              inst_vld;
  logic [DATA_W-1:0] inst_wd;
  logic              inst_drop;

  modport master (input inst_rdy, output inst_vld, output inst_wd, output inst_drop);
  modport slave  (output inst_rdy, input inst_vld, input inst_wd, input inst_drop);

endinterface

// File: rtl/inst_capture_debounce.sv
// Two-flop synchroniser plus stable-run debouncer for one raw button; flags the
// accepted 0->1 transition combinationally on the edge where it is accepted.
module debounce #(
  parameter int DEB_CYCLES = inst_capture_pkg::DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             btn_s_q, btn_s_d;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    btn_s_d  = sync1_q;
    btn_db_d = btn_db_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    // Any sample that agrees with the accepted level restarts the stable run.
    if (btn_s_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      btn_db_d = btn_s_q;
      cnt_d    = '0;
      rise     = btn_s_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      btn_s_q  <= 1'b0;
      btn_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      btn_s_q  <= btn_s_d;
      btn_db_q <= btn_db_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = btn_db_q;

endmodule

// File: rtl/inst_capture.sv
// Instruction capture: latches the synchronised switch word on each debounced
// step press and hands it to the core with a one-cycle strobe once it is ready.
module inst_capture
  import inst_capture_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step,
  input  logic [DATA_W-1:0] sw,
  inst_capture_if.master    cap
);

  logic              press;
  logic              btn_level_unused;
  logic [DATA_W-1:0] sw_sync1_q, sw_sync1_d;
  logic [DATA_W-1:0] sw_s_q, sw_s_d;
  cap_state_e        state_q, state_d;
  logic              inst_vld_q, inst_vld_d;
  logic              inst_drop_q, inst_drop_d;
  logic [DATA_W-1:0] inst_wd_q, inst_wd_d;

  debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_db (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_step),
    .dout (btn_level_unused),
    .rise (press)
  );

  always_comb begin
    sw_sync1_d  = sw;
    sw_s_d      = sw_sync1_q;
    state_d     = state_q;
    inst_vld_d  = 1'b0;
    inst_drop_d = 1'b0;
    inst_wd_d   = inst_wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          inst_wd_d = sw_s_q;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        // Only one word is buffered: a press arriving now is lost, even on the issue edge.
        if (cap.inst_rdy) begin
          inst_vld_d = 1'b1;
          state_d    = ST_IDLE;
        end
        inst_drop_d = press;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync1_q  <= '0;
      sw_s_q      <= '0;
      state_q     <= ST_IDLE;
      inst_vld_q  <= 1'b0;
      inst_drop_q <= 1'b0;
      inst_wd_q   <= '0;
    end else begin
      sw_sync1_q  <= sw_sync1_d;
      sw_s_q      <= sw_s_d;
      state_q     <= state_d;
      inst_vld_q  <= inst_vld_d;
      inst_drop_q <= inst_drop_d;
      inst_wd_q   <= inst_wd_d;
    end
  end

  assign cap.inst_vld  = inst_vld_q;
  assign cap.inst_drop = inst_drop_q;
  assign cap.inst_wd   = inst_wd_q;

endmodule

// File: tb/tb_inst_capture.sv
// Scoreboard bench for inst_capture: a cycle-level reference of the press rules
// predicts strobes and drops; a negedge monitor compares them against the DUT.
module tb_inst_capture;

  localparam int DEB = 4;

  typedef struct {
    bit       is_drop;
    bit [7:0] word;
    int       ecyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_step;
  logic [7:0] sw;

  inst_capture_if cap_if ();

  inst_capture #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .sw       (sw),
    .cap      (cap_if)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];

  // Reference state: input history, accepted button level, run length, buffered word.
  bit       bq[$];
  bit [7:0] sq[$];
  bit       m_db;
  int       m_run;
  bit       m_pend;
  bit [7:0] m_word;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic model_clear();
    bq = '{0, 0};
    sq = '{0, 0};
    m_db   = 0;
    m_run  = 0;
    m_pend = 0;
    m_word = 0;
  endtask

  initial model_clear();

  // Reference model: a level is accepted after DEB consecutive edges on which the
  // (two-edge delayed) button disagrees with the accepted level.
  always @(posedge clk) begin
    bit       synced;
    bit [7:0] ssw;
    bit       pr;
    exp_t     e;
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      synced = bq[1];
      ssw    = sq[1];
      void'(bq.pop_back());
      bq.push_front(btn_step);
      void'(sq.pop_back());
      sq.push_front(sw);
      pr = 0;
      if (synced != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db  = synced;
          m_run = 0;
          pr    = synced;
        end
      end else begin
        m_run = 0;
      end
      if (m_pend) begin
        if (cap_if.inst_rdy) begin
          e = '{is_drop: 0, word: m_word, ecyc: cyc};
          exp_q.push_back(e);
          m_pend = 0;
        end
        if (pr) begin
          e = '{is_drop: 1, word: m_word, ecyc: cyc};
          exp_q.push_back(e);
        end
      end else if (pr) begin
        m_pend = 1;
        m_word = ssw;
      end
    end
  end

  // Monitor: collect what is due this cycle and compare with the registered outputs.
  always @(negedge clk) begin
    bit       ev;
    bit       ed;
    bit [7:0] ew;
    exp_t     e;
    ev = 0;
    ed = 0;
    ew = 0;
    while (exp_q.size() > 0 && exp_q[0].ecyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.ecyc < cyc) chk("stale_expectation", e.ecyc, cyc);
      if (e.is_drop) ed = 1;
      else begin
        ev = 1;
        ew = e.word;
      end
    end
    chk("inst_vld", int'(cap_if.inst_vld), int'(ev));
    chk("inst_drop", int'(cap_if.inst_drop), int'(ed));
    if (ev) chk("issued_word", int'(cap_if.inst_wd), int'(ew));
    chk("inst_wd_hold", int'(cap_if.inst_wd), int'(m_word));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit [7:0] val, input int hold, input int rel);
    sw       = val;
    btn_step = 1'b1;
    wait_cyc(hold);
    btn_step = 1'b0;
    wait_cyc(rel);
  endtask

  initial begin
    int e0;
    int hold;
    rst             = 1'b1;
    btn_step        = 1'b0;
    sw              = 8'h00;
    cap_if.inst_rdy = 1'b0;
    wait_cyc(3);
    chk("reset_vld", int'(cap_if.inst_vld), 0);
    chk("reset_drop", int'(cap_if.inst_drop), 0);
    chk("reset_wd", int'(cap_if.inst_wd), 0);
    rst = 1'b0;
    wait_cyc(2);

    // Clean press: strobe lands right after edge DEB+2 counted from the first sampling edge.
    sw              = 8'h04;
    cap_if.inst_rdy = 1'b1;
    btn_step        = 1'b1;
    e0              = cyc + 1;
    for (int i = 0; i < 40 && !cap_if.inst_vld; i++) @(negedge clk);
    chk("press_latency", cyc - e0, DEB + 2);
    chk("clean_wd", int'(cap_if.inst_wd), 8'h04);
    wait_cyc(20 - (cyc - e0 + 1));
    btn_step = 1'b0;
    wait_cyc(12);

    // Glitch shorter than the debounce interval, from a freshly reset word.
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    press(8'h77, 3, 12);
    chk("glitch_wd", int'(cap_if.inst_wd), 8'h00);

    // Bounce 1,0,1,0 then settle high.
    sw = 8'h3C;
    btn_step = 1'b1; wait_cyc(1);
    btn_step = 1'b0; wait_cyc(1);
    btn_step = 1'b1; wait_cyc(1);
    btn_step = 1'b0; wait_cyc(1);
    press(8'h3C, 15, 12);
    chk("bounce_wd", int'(cap_if.inst_wd), 8'h3C);

    // Busy core, then a second press while pending.
    cap_if.inst_rdy = 1'b0;
    press(8'h91, 12, 10);
    chk("busy_no_vld", int'(cap_if.inst_vld), 0);
    press(8'hC0, 10, 10);
    chk("pending_wd_kept", int'(cap_if.inst_wd), 8'h91);
    cap_if.inst_rdy = 1'b1;
    wait_cyc(3);
    chk("busy_issued_wd", int'(cap_if.inst_wd), 8'h91);

    // Reset while pending discards the word.
    cap_if.inst_rdy = 1'b0;
    press(8'h5A, 10, 10);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst_pend_vld", int'(cap_if.inst_vld), 0);
    chk("rst_pend_drop", int'(cap_if.inst_drop), 0);
    chk("rst_pend_wd", int'(cap_if.inst_wd), 0);
    cap_if.inst_rdy = 1'b1;
    wait_cyc(20);

    // Switch change after capture must not leak into the issued word.
    cap_if.inst_rdy = 1'b0;
    sw       = 8'h55;
    btn_step = 1'b1;
    wait_cyc(10);
    sw       = 8'hAA;
    btn_step = 1'b0;
    wait_cyc(10);
    cap_if.inst_rdy = 1'b1;
    wait_cyc(3);
    chk("sw_change_wd", int'(cap_if.inst_wd), 8'h55);

    // Button held through reset gives exactly one press after release.
    sw       = 8'hE1;
    btn_step = 1'b1;
    rst      = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(15);
    btn_step = 1'b0;
    wait_cyc(10);
    chk("held_reset_wd", int'(cap_if.inst_wd), 8'hE1);

    // Randomised phase.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hold     = $urandom_range(1, 8);
        if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      end
      hold--;
      cap_if.inst_rdy = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst             = 1'b0;
    btn_step        = 1'b0;
    cap_if.inst_rdy = 1'b1;
    wait_cyc(20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
